// File: rtl/mod_counter_chain_pkg.sv
// Shared types, constants and helpers for the cascaded modulo counter.
// Stage moduli are carried as 32-bit fields packed into one vector, with stage 0 at the LSBs.
package mod_counter_pkg;

    localparam int MAX_STAGES = 32;
    localparam int MOD_BUS_W  = MAX_STAGES * 32;

    // hundredths, tenths, seconds, tens-of-seconds
    localparam logic [127:0] DEFAULT_STOPWATCH_MODS = {32'd6, 32'd10, 32'd10, 32'd10};

    function automatic logic [31:0] get_mod(input logic [MOD_BUS_W-1:0] mods, input int i);
        return mods[32*i +: 32];
    endfunction

    function automatic logic [31:0] clamp(input logic [31:0] digit, input logic [31:0] modulus);
        return (digit >= modulus) ? modulus - 32'd1 : digit;
    endfunction

endpackage

// File: rtl/mod_counter_chain_if.sv
// Control and status bundle of the counter chain.
// The master drives the step and load controls; the slave returns the counts and pulses.
interface mod_counter_chain_if #(
    parameter int NUM_STAGES = 4,
    parameter int WIDTH      = 4
);
    logic                          increment;
    logic                          down;
    logic                          load;
    logic [NUM_STAGES*WIDTH-1:0]   load_value;
    logic [NUM_STAGES*WIDTH-1:0]   count;
    logic [NUM_STAGES-1:0]         rollover;
    logic                          overflow;
    logic                          terminal;

    modport master (
        output increment, down, load, load_value,
        input  count, rollover, overflow, terminal
    );

    modport slave (
        input  increment, down, load, load_value,
        output count, rollover, overflow, terminal
    );
endinterface

// File: rtl/mod_counter_chain_stage.sv
// One modulo-M digit of the counter chain, counting up or down with a synchronous clamped load.
// Its terminal flag follows the current direction, so a carry can ripple through every stage in one cycle.
module mod_counter_stage
    import mod_counter_pkg::*;
#(
    parameter int          WIDTH     = 4,
    parameter logic [31:0] MOD_VALUE = 32'd10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             carry_in,
    input  logic             down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_digit,
    output logic [WIDTH-1:0] count,
    output logic             carry_out,
    output logic             at_terminal
);

    if (MOD_VALUE < 32'd2 || 64'(MOD_VALUE) > (64'd1 << WIDTH)) begin : g_bad_mod
        $fatal(1, "mod_counter_stage: modulus %0d out of range for WIDTH %0d", MOD_VALUE, WIDTH);
    end

    localparam logic [WIDTH-1:0] TOP = WIDTH'(MOD_VALUE - 32'd1);

    logic [WIDTH-1:0] load_clamped;

    assign load_clamped = WIDTH'(clamp(32'(load_digit), MOD_VALUE));
    assign at_terminal  = down ? (count == '0) : (count == TOP);
    assign carry_out    = carry_in & at_terminal;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_clamped;
        end else if (carry_in) begin
            if (at_terminal)
                count <= down ? TOP : '0;
            else
                count <= down ? count - 1'b1 : count + 1'b1;
        end
    end

endmodule

// File: rtl/mod_counter_chain.sv
// Cascade of modulo digits with a ripple carry, registered rollover and overflow pulses,
// and optional saturation of the whole chain at its terminal value.
module mod_counter_chain
    import mod_counter_pkg::*;
#(
    parameter int                        NUM_STAGES = 4,
    parameter int                        WIDTH      = 4,
    parameter logic [NUM_STAGES*32-1:0]  MOD_VALUES = DEFAULT_STOPWATCH_MODS,
    parameter bit                        WRAP_MODE  = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    mod_counter_chain_if.slave  bus
);

    if (NUM_STAGES < 1 || NUM_STAGES > MAX_STAGES) begin : g_bad_stages
        $fatal(1, "mod_counter_chain: NUM_STAGES %0d out of range", NUM_STAGES);
    end

    localparam logic [MOD_BUS_W-1:0] MOD_BUS = MOD_BUS_W'(MOD_VALUES);

    logic [NUM_STAGES:0]          carry;
    logic [NUM_STAGES-1:0]        stage_term;
    logic [NUM_STAGES*WIDTH-1:0]  count_all;
    logic                         chain_terminal;
    logic [NUM_STAGES-1:0]        rollover_q;
    logic                         overflow_q;

    assign chain_terminal = &stage_term;
    // In saturate mode a step at the terminal value is swallowed before it reaches the chain.
    assign carry[0] = bus.increment & ~(chain_terminal & ~WRAP_MODE);

    for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
        mod_counter_stage #(
            .WIDTH     (WIDTH),
            .MOD_VALUE (get_mod(MOD_BUS, i))
        ) u_stage (
            .clk         (clk),
            .reset       (reset),
            .carry_in    (carry[i]),
            .down        (bus.down),
            .load        (bus.load),
            .load_digit  (bus.load_value[WIDTH*i +: WIDTH]),
            .count       (count_all[WIDTH*i +: WIDTH]),
            .carry_out   (carry[i+1]),
            .at_terminal (stage_term[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset || bus.load) begin
            rollover_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            rollover_q <= carry[NUM_STAGES:1];
            overflow_q <= bus.increment & chain_terminal;
        end
    end

    assign bus.count    = count_all;
    assign bus.rollover = rollover_q;
    assign bus.overflow = overflow_q;
    assign bus.terminal = chain_terminal;

endmodule

// File: tb/tb_mod_counter_chain.sv
// Directed test of the stopwatch-configured counter chain in wrap and saturate modes.
module tb_mod_counter_chain;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    mod_counter_chain_if #(.NUM_STAGES(4), .WIDTH(4)) if_w ();
    mod_counter_chain_if #(.NUM_STAGES(4), .WIDTH(4)) if_s ();

    mod_counter_chain #(.WRAP_MODE(1'b1)) dut_wrap (.clk(clk), .reset(reset), .bus(if_w.slave));
    mod_counter_chain #(.WRAP_MODE(1'b0)) dut_sat  (.clk(clk), .reset(reset), .bus(if_s.slave));

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs to both chains, then return just after the edge.
    task automatic cycle(input logic rst, input logic inc, input logic dn,
                         input logic ld, input logic [15:0] lv);
        @(negedge clk);
        reset           = rst;
        if_w.increment  = inc;  if_s.increment  = inc;
        if_w.down       = dn;   if_s.down       = dn;
        if_w.load       = ld;   if_s.load       = ld;
        if_w.load_value = lv;   if_s.load_value = lv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        if_w.increment = 1'b0; if_w.down = 1'b0; if_w.load = 1'b0; if_w.load_value = '0;
        if_s.increment = 1'b0; if_s.down = 1'b0; if_s.load = 1'b0; if_s.load_value = '0;

        // Reset state
        cycle(1, 0, 0, 0, 16'h0000);
        check_val("reset_count", 32'(if_w.count), 32'h0000);
        check_val("reset_rollover", 32'(if_w.rollover), 32'h0);
        check_val("reset_overflow", 32'(if_w.overflow), 32'h0);

        // Ten up steps: digit 0 wraps on the tenth edge only
        for (int i = 1; i <= 10; i++) begin
            cycle(0, 1, 0, 0, 16'h0000);
            if (i < 10) check_val("up10_no_rollover", 32'(if_w.rollover), 32'h0);
        end
        check_val("up10_count", 32'(if_w.count), 32'h0010);
        check_val("up10_rollover", 32'(if_w.rollover), 32'h1);
        check_val("up10_overflow", 32'(if_w.overflow), 32'h0);
        cycle(0, 0, 0, 0, 16'h0000);
        check_val("up10_rollover_clear", 32'(if_w.rollover), 32'h0);

        // Full-chain wrap from 5999
        cycle(0, 0, 0, 1, 16'h5999);
        check_val("load5999_count", 32'(if_w.count), 32'h5999);
        check_val("load5999_terminal", 32'(if_w.terminal), 32'h1);
        cycle(0, 1, 0, 0, 16'h0000);
        check_val("wrap_count", 32'(if_w.count), 32'h0000);
        check_val("wrap_rollover", 32'(if_w.rollover), 32'hF);
        check_val("wrap_overflow", 32'(if_w.overflow), 32'h1);
        cycle(0, 0, 0, 0, 16'h0000);
        check_val("wrap_rollover_clear", 32'(if_w.rollover), 32'h0);
        check_val("wrap_overflow_clear", 32'(if_w.overflow), 32'h0);

        // Down from zero wraps to 5999, then steps normally
        cycle(1, 0, 0, 0, 16'h0000);
        @(negedge clk);
        if_w.down = 1'b1;
        #1;
        check_val("down_terminal_at_zero", 32'(if_w.terminal), 32'h1);
        cycle(0, 1, 1, 0, 16'h0000);
        check_val("down_wrap_count", 32'(if_w.count), 32'h5999);
        check_val("down_wrap_rollover", 32'(if_w.rollover), 32'hF);
        check_val("down_wrap_overflow", 32'(if_w.overflow), 32'h1);
        cycle(0, 1, 1, 0, 16'h0000);
        check_val("down_step_count", 32'(if_w.count), 32'h5998);
        check_val("down_step_rollover", 32'(if_w.rollover), 32'h0);
        check_val("down_step_overflow", 32'(if_w.overflow), 32'h0);

        // Load with clamping wins over a same-cycle increment
        cycle(0, 1, 0, 1, 16'h7ABC);
        check_val("clamp_count", 32'(if_w.count), 32'h5999);
        check_val("clamp_rollover", 32'(if_w.rollover), 32'h0);
        check_val("clamp_overflow", 32'(if_w.overflow), 32'h0);
        check_val("clamp_count_sat", 32'(if_s.count), 32'h5999);

        // Saturate mode holds at terminal but still flags overflow
        cycle(0, 1, 0, 0, 16'h0000);
        check_val("sat_hold_count", 32'(if_s.count), 32'h5999);
        check_val("sat_hold_overflow", 32'(if_s.overflow), 32'h1);
        check_val("sat_hold_rollover", 32'(if_s.rollover), 32'h0);
        check_val("wrap_side_count", 32'(if_w.count), 32'h0000);
        cycle(0, 1, 1, 0, 16'h0000);
        check_val("sat_down_count", 32'(if_s.count), 32'h5998);
        check_val("sat_down_overflow", 32'(if_s.overflow), 32'h0);

        // Reset overrides a same-cycle increment
        cycle(1, 0, 0, 0, 16'h0000);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 16'h0000);
        check_val("pre_reset_count", 32'(if_w.count), 32'h0003);
        cycle(1, 1, 0, 0, 16'h0000);
        check_val("reset_inc_count", 32'(if_w.count), 32'h0000);
        check_val("reset_inc_rollover", 32'(if_w.rollover), 32'h0);
        check_val("reset_inc_overflow", 32'(if_w.overflow), 32'h0);

        // Gapped increments advance once each
        for (int k = 1; k <= 4; k++) begin
            cycle(0, 1, 0, 0, 16'h0000);
            check_val("gap_step", 32'(if_w.count), 32'(k));
            cycle(0, 0, 0, 0, 16'h0000);
            cycle(0, 0, 0, 0, 16'h0000);
            check_val("gap_hold", 32'(if_w.count), 32'(k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
